p_accept: RTL
=============

# p_accept

Input-side accept arbiter for the pSLIP scheduler, the receiving end of the output-side grant stage. Each scheduling round it collects one-hot grant vectors from the N output ports across up to ITER iterations. It accepts at most one grant per round using a round-robin accept pointer and returns a one-hot accept vector to the grant stage. The pointer advances only on a first-iteration accept, per iSLIP, which keeps the schedule desynchronised.

## Interface
- N, default 4: number of output ports; legal values 4, 8, 16, 32.
- ITER, default 4: iterations per scheduling round; legal range 1..N.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a scheduling round.
- grant_valid  input  1  qualifies grant_in for one iteration.
- grant_in  input  N  bit j set means output j grants this input; any number of bits may be set.
- accept  output  N  registered one-hot accept, or all zeros.
- accept_valid  output  1  registered; one pulse per processed iteration.
- match_vec  output  N  one-hot output accepted this round; held until the next start.
- matched  output  1  equals the OR of match_vec bits.
- done  output  1  one-cycle pulse marking the end of the round.
- busy  output  1  high while the FSM is in RUN.

## Operation
- FSM states are IDLE and RUN.
- IDLE → RUN on start. On that edge: iter_cnt=0, match_vec=0.
- RUN: each grant_valid is one iteration and increments iter_cnt.
  - On the grant_valid where iter_cnt==ITER-1, return to IDLE.
- start in RUN: ignored.
- grant_valid in IDLE: ignored; no accept_valid.
- grant_in with grant_valid low: ignored.
- Per iteration:
  - If matched==0 and grant_in!=0: accept is the granted bit with the lowest index ≥ acc_ptr, wrapping past N-1 to 0. match_vec takes that one-hot value.
  - Otherwise accept=0. A held match is never replaced.
- acc_ptr, width clog2(N):
  - On an accept in iteration 0 only: acc_ptr = (index+1) mod N.
  - Accepts in later iterations, and empty iterations, leave acc_ptr unchanged.
  - acc_ptr persists across rounds.
- With acc_ptr=0, selection is plain lowest-index-wins priority.
- Index arithmetic is modulo N. The wrap search is a rotate by acc_ptr, a fixed-priority pick, then a rotate back.

## Timing
- Reset values: accept=0, accept_valid=0, match_vec=0, matched=0, done=0, busy=0, acc_ptr=0, iter_cnt=0, state=IDLE.
- Latency: grant_valid at edge t produces accept/accept_valid during cycle t+1 (one register stage).
- accept_valid is high for exactly one cycle per processed iteration. It stays low otherwise, and accept=0 whenever accept_valid=0.
- matched and match_vec update in the same cycle as the corresponding accept_valid.
- done pulses in the same cycle as the last iteration's accept_valid. busy falls in that same cycle.
- start in the cycle done is high is legal and opens a new round immediately.
- Back-to-back grant_valid is legal; one iteration per cycle.
- Gaps between iterations are legal; the round waits in RUN with no timeout.
- Asserting rst in any state, including mid-round, clears every register to its reset value asynchronously. acc_ptr returns to 0. An in-flight accept_valid or done is not emitted.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately; after release, acc_ptr=0 and busy=0.
- First-iteration accept (acc_ptr=0): start, then grant_valid with grant_in=0110 → next cycle accept=0010, accept_valid=1, matched=1; acc_ptr=2.
- Wrap: acc_ptr=2, new round, iteration-0 grant_in=0011 → accept=0001; acc_ptr=1.
- Later-iteration accept (acc_ptr=1, ITER=4):
  - iter 0 grant_in=0000 → accept=0000.
  - iter 1 grant_in=1000 → accept=1000, acc_ptr stays 1.
  - iter 2 grant_in=0100 → accept=0000, match_vec stays 1000.
- Round end: grant_valid at cycles 2, 4, 5, 7 with a start pulse at cycle 3 → start ignored; done=1 and busy=0 at cycle 8; exactly four accept_valid pulses.
- Mid-round reset: rst at cycle between iterations 1 and 2 → match_vec=0, acc_ptr=0; a subsequent grant_valid without start produces no accept_valid.

Source files
------------

// File: rtl/p_accept.sv
// Input-side accept arbiter for the pSLIP scheduler.
// Accepts at most one grant per round using a round-robin accept pointer.
module p_accept #(
    parameter int N    = 4,
    parameter int ITER = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         grant_valid,
    input  logic [N-1:0] grant_in,
    output logic [N-1:0] accept,
    output logic         accept_valid,
    output logic [N-1:0] match_vec,
    output logic         matched,
    output logic         done,
    output logic         busy
);

    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(ITER - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   iter_cnt;
    logic [PW-1:0]   acc_ptr;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [PW-1:0]   off;
    logic            found;
    logic [PW-1:0]   idx;
    logic [N-1:0]    sel;
    logic            iter_go;
    logic            take;
    logic            last;

    assign iter_go = (state == RUN) && grant_valid;
    assign take    = iter_go && !matched && (grant_in != '0);
    assign last    = (iter_cnt == LAST);
    assign matched = |match_vec;
    assign busy    = (state == RUN);

    // Rotate so acc_ptr lands at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        dbl   = {grant_in, grant_in} >> acc_ptr;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = PW'(i);
            end
        end
        idx = acc_ptr + off;
        sel = N'(1) << idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (grant_valid && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt     <= '0;
            acc_ptr      <= '0;
            accept       <= '0;
            accept_valid <= 1'b0;
            match_vec    <= '0;
            done         <= 1'b0;
        end else begin
            accept       <= '0;
            accept_valid <= 1'b0;
            done         <= 1'b0;
            if (state == IDLE && start) begin
                iter_cnt  <= '0;
                match_vec <= '0;
            end
            if (iter_go) begin
                accept_valid <= 1'b1;
                iter_cnt     <= iter_cnt + 1'b1;
                done         <= last;
                if (take) begin
                    accept    <= sel;
                    match_vec <= sel;
                    // Only first-iteration accepts move the pointer.
                    if (iter_cnt == '0) acc_ptr <= idx + 1'b1;
                end
            end
        end
    end

endmodule
